tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
Parametrised successor to the single-channel active-low-enable tristate driver. NCH channels share one WIDTH-bit tristate bus. Each channel is granted ownership round-robin. Drive data is registered. The bus is released to high-Z for a guaranteed turnaround gap between owners, so two channels never drive it at the same time. A bus-hold limit stops one channel from monopolising the bus. The block sits between local requesters and a shared off-block or inter-block bidirectional bus.

Parameters:
WIDTH, 8, bus and per-channel data width in bits (>=1)
NCH, 4, number of requesting channels (2..16)
TURN, 1, high-Z turnaround cycles between owners (>=1)
MAXHOLD, 16, max consecutive DRIVE cycles while another channel is requesting (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NCH  per-channel drive request; level, held while the channel wants the bus
din  input  NCH*WIDTH  per-channel drive data; channel i occupies bits [i*WIDTH +: WIDTH]
gnt  output  NCH  one-hot grant (registered); bit i high exactly while channel i's data is on the bus
bus  inout  WIDTH  shared tristate bus; driven only in DRIVE, all-Z otherwise
bus_rx  output  WIDTH  bus value registered every cycle (1-cycle latency)
busy  output  1  high in DRIVE or TURN

Behaviour:
- Reset (async, rst_n=0), taking effect immediately without a clock edge:
  - state=IDLE, gnt=0, bus all-Z, busy=0, bus_rx=0, hold_cnt=0, turn_cnt=0, rr_ptr=0 (channel 0 has highest priority first).
- Reset asserted mid-DRIVE releases the bus to Z in the same cycle.
- Round-robin choice: the first requesting channel scanning rr_ptr, rr_ptr+1, ... modulo NCH. On a grant to channel c, rr_ptr is set to (c+1) mod NCH.
- IDLE:
  - If any req is high at a rising edge, go to DRIVE and set gnt to onehot(c), data_q=din[c], hold_cnt=1.
  - Otherwise stay in IDLE.
  - Latency from req rising to data on the bus: 1 cycle.
- DRIVE (owner c):
  - bus=data_q; data_q<=din[c] every edge, so bus follows din with 1-cycle latency.
  - The state is evaluated at each edge; the first matching rule applies:
    1. req[c]=0: go to TURN.
    2. hold_cnt==MAXHOLD and any other req is high: go to TURN (forced release; c keeps requesting but loses priority via rr_ptr).
    3. Otherwise stay in DRIVE. hold_cnt increments and saturates at MAXHOLD. It only forces release when others are waiting, so a sole requester holds the bus indefinitely.
  - On entering TURN: gnt<=0, bus Z, turn_cnt<=TURN.
- TURN:
  - bus Z, gnt 0, busy 1.
  - Each edge, turn_cnt decrements. At the edge where turn_cnt==1, arbitration is performed: go to DRIVE with the new owner if any req is high, else go to IDLE.
  - The gap between owners is exactly TURN all-Z cycles.
  - The previous owner is eligible again according to rr_ptr.
- gnt and bus enable come from the same registered state, so there is no glitch. gnt is never multi-hot. The bus is never driven in IDLE or TURN.
- req changing during TURN is sampled only at the arbitration edge. A req pulse that falls before the arbitration edge is ignored (no latching).
- bus_rx <= bus every edge. When the bus is Z, the value is whatever external pull/keeper provides; the bench supplies a pull-down.

Test Plan:
1. Reset with req=4'b0101 held and rst_n low -> gnt=0, bus=Z, busy=0. After release, first edge gives gnt=0001 and bus=din[0] on the next cycle.
2. Single requester: channel 2 with req high for 40 cycles, din incrementing 0x10,0x11,... -> gnt=0100 for all 40 cycles (no forced release), bus lags din by 1 cycle. After req drops: 1 Z cycle, then IDLE.
3. Contention: req=4'b1111 constant, MAXHOLD=16, TURN=1 -> grants rotate 0->1->2->3->0. Each owner holds 16 cycles, with exactly 1 Z cycle between owners; no cycle has two drivers.
4. TURN=3, channel 1 drops req while channel 3 is requesting -> exactly 3 all-Z cycles, then gnt=1000.
5. Async reset mid-DRIVE (channel 3 driving 0xA5) -> bus goes Z and gnt=0 immediately, before the next edge. rr_ptr=0 after release.
6. Glitch: channel 0 raises req for 1 cycle during TURN, not at the arbitration edge -> no grant. The arbiter returns to IDLE with bus Z.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tristate bus.
// NCH requesters take turns driving one WIDTH-bit bidirectional bus. Drive
// data is registered. Every change of owner goes through TURN all-Z cycles,
// so two channels never drive the bus at once. A hold limit (MAXHOLD) makes
// the owner give up the bus when another channel is waiting.
//
// Handshake: req[i] is a level request with no ready/ack. gnt[i] is high
// exactly while channel i's registered data is on the bus. A requester keeps
// req high for as long as it wants the bus. Requests are sampled only at
// arbitration edges and are never latched.
module tristate_bus_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [NCH-1:0]       gnt,
    inout  wire  [WIDTH-1:0]     bus,
    output logic [WIDTH-1:0]     bus_rx,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HW = $clog2(MAXHOLD + 1);
    localparam int TW = $clog2(TURN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [WIDTH-1:0]  data_q;
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     turn_cnt;
    logic              drive_en;

    logic              pick_valid;
    logic [PW-1:0]     pick_idx;
    logic [PW:0]       scan_sum;
    logic              others_req;
    logic              do_grant;
    logic [WIDTH-1:0]  owner_din;

    // The bus is driven only from registered state, so reset releases it at once.
    assign bus       = drive_en ? data_q : {WIDTH{1'bz}};
    assign state_dbg = state;
    assign owner_din = din[int'(owner)*WIDTH +: WIDTH];

    // Round-robin scan: the first requesting channel at rr_ptr, rr_ptr+1, ... mod NCH.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        // The scan runs in descending order, so the smallest offset from rr_ptr is written last and wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(NCH)) begin
                scan_sum = scan_sum - (PW+1)'(NCH);
            end
            if (req[scan_sum[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_sum[PW-1:0];
            end
        end
    end

    // Another channel is waiting while the current owner drives.
    always_comb begin
        others_req = |(req & ~gnt);
        do_grant   = pick_valid &&
                     ((state == S_IDLE) ||
                      ((state == S_TURN) && (turn_cnt == TW'(1))));
    end

    // Main FSM with registered gnt, bus enable, busy and drive data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gnt      <= '0;
            drive_en <= 1'b0;
            busy     <= 1'b0;
            bus_rx   <= '0;
            data_q   <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            bus_rx <= bus;
            case (state)
                S_IDLE: begin
                    // Leaving IDLE is handled by the grant branch below.
                end
                S_DRIVE: begin
                    data_q <= owner_din;
                    if (!req[owner] ||
                        ((hold_cnt == HW'(MAXHOLD)) && others_req)) begin
                        state    <= S_TURN;
                        gnt      <= '0;
                        drive_en <= 1'b0;
                        turn_cnt <= TW'(TURN);
                    end else if (hold_cnt != HW'(MAXHOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_TURN: begin
                    turn_cnt <= turn_cnt - 1'b1;
                    if ((turn_cnt == TW'(1)) && !pick_valid) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    gnt      <= '0;
                    drive_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
            // A new owner is granted from IDLE or on the last turnaround edge.
            if (do_grant) begin
                state    <= S_DRIVE;
                owner    <= pick_idx;
                gnt      <= {{(NCH-1){1'b0}}, 1'b1} << pick_idx;
                drive_en <= 1'b1;
                busy     <= 1'b1;
                data_q   <= din[int'(pick_idx)*WIDTH +: WIDTH];
                hold_cnt <= HW'(1);
                rr_ptr   <= (pick_idx == PW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter. Two instances share the same req/din:
// instance A uses TURN=1 and MAXHOLD=16, and instance B uses TURN=3 and
// MAXHOLD=5. Each bus has a pull-down, so a released bus reads as zero.
// A cycle-level reference model built from the arbitration rules predicts
// every output of both instances after every edge.
module tb_tristate_bus_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int T_A = 1;
    localparam int H_A = 16;
    localparam int T_B = 3;
    localparam int H_B = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;

    logic [N-1:0]     gnt_a, gnt_b;
    wire  [W-1:0]     bus_a, bus_b;
    logic [W-1:0]     rx_a, rx_b;
    logic             busy_a, busy_b;
    logic [1:0]       st_a, st_b;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state, indexed by instance (0 = A, 1 = B).
    int           m_own [2];
    int           m_hold[2];
    int           m_gap [2];
    int           m_ptr [2];
    logic [W-1:0] m_data[2];
    logic [W-1:0] m_rx  [2];

    pulldown (bus_a);
    pulldown (bus_b);

    tristate_bus_arbiter #(.WIDTH(W), .NCH(N), .TURN(T_A), .MAXHOLD(H_A)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_a),
        .bus(bus_a), .bus_rx(rx_a), .busy(busy_a), .state_dbg(st_a)
    );

    tristate_bus_arbiter #(.WIDTH(W), .NCH(N), .TURN(T_B), .MAXHOLD(H_B)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_b),
        .bus(bus_b), .bus_rx(rx_b), .busy(busy_b), .state_dbg(st_b)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Timeout guard.
    initial begin
        #2000000;
        $display("FAIL timeout: run did not finish (got running, need finished)");
        $fatal(1, "timeout");
    end

    function automatic int turn_of(input int k);
        return (k == 0) ? T_A : T_B;
    endfunction

    function automatic int maxh_of(input int k);
        return (k == 0) ? H_A : H_B;
    endfunction

    function automatic logic [W-1:0] m_bus(input int k);
        return (m_own[k] >= 0) ? m_data[k] : '0;
    endfunction

    function automatic logic [N-1:0] m_gnt(input int k);
        return (m_own[k] >= 0) ? (N'(1) << m_own[k]) : '0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_hold[k] = 0;
            m_gap[k]  = 0;
            m_ptr[k]  = 0;
            m_data[k] = '0;
            m_rx[k]   = '0;
        end
    endtask

    // One rising edge of the model. r and d are the values sampled at that edge.
    task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] d);
        int o;
        int c;
        for (int k = 0; k < 2; k++) begin
            m_rx[k] = m_bus(k);
            if (m_own[k] >= 0) begin
                o = m_own[k];
                if (!r[o] || (m_hold[k] >= maxh_of(k) && (r & ~(N'(1) << o)) != '0)) begin
                    m_own[k] = -1;
                    m_gap[k] = turn_of(k);
                end else begin
                    m_data[k] = d[o*W +: W];
                    if (m_hold[k] < maxh_of(k)) m_hold[k] = m_hold[k] + 1;
                end
            end else if (m_gap[k] > 1) begin
                m_gap[k] = m_gap[k] - 1;
            end else begin
                m_gap[k] = 0;
                for (int s = 0; s < N; s++) begin
                    c = (m_ptr[k] + s) % N;
                    if (r[c]) begin
                        m_own[k]  = c;
                        m_data[k] = d[c*W +: W];
                        m_hold[k] = 1;
                        m_ptr[k]  = (c + 1) % N;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gnt_a"},  32'(gnt_a),  32'(m_gnt(0)));
        chk({tag, ".bus_a"},  32'(bus_a),  32'(m_bus(0)));
        chk({tag, ".rx_a"},   32'(rx_a),   32'(m_rx[0]));
        chk({tag, ".busy_a"}, 32'(busy_a), 32'((m_own[0] >= 0) || (m_gap[0] > 0)));
        chk({tag, ".oh_a"},   32'($onehot0(gnt_a)), 32'd1);
        chk({tag, ".gnt_b"},  32'(gnt_b),  32'(m_gnt(1)));
        chk({tag, ".bus_b"},  32'(bus_b),  32'(m_bus(1)));
        chk({tag, ".rx_b"},   32'(rx_b),   32'(m_rx[1]));
        chk({tag, ".busy_b"}, 32'(busy_b), 32'((m_own[1] >= 0) || (m_gap[1] > 0)));
        chk({tag, ".oh_b"},   32'($onehot0(gnt_b)), 32'd1);
    endtask

    // Waits for the next edge, advances the model and checks both instances.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_edge(req, din);
        #1;
        check_all(tag);
    endtask

    initial begin
        int cnt;
        int zc;

        // Reset held while requests are present.
        rst_n = 1'b1;
        req   = '0;
        din   = '0;
        #1;
        rst_n = 1'b0;
        model_reset();
        req = 4'b0101;
        din = 32'h44_33_22_11;
        #1;
        check_all("t1_reset");
        chk("t1_reset_gnt", 32'(gnt_a), 32'd0);
        chk("t1_reset_busy", 32'(busy_a), 32'd0);
        step("t1_in_reset");
        step("t1_in_reset");
        #3;
        rst_n = 1'b1;
        step("t1_first");
        chk("t1_first_gnt", 32'(gnt_a), 32'h1);
        chk("t1_first_bus", 32'(bus_a), 32'h11);
        step("t1_hold");
        step("t1_hold");
        req = '0;
        for (int i = 0; i < 6; i++) step("t1_idle");

        // Single requester on channel 2 for 40 cycles.
        req = 4'b0100;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            din[2*W +: W] = 8'(8'h10 + k);
            step("t2_single");
            if (gnt_a == 4'b0100) cnt++;
        end
        chk("t2_gnt_cycles", 32'(cnt), 32'd40);
        req = '0;
        step("t2_turn");
        chk("t2_turn_busy", 32'(busy_a), 32'd1);
        step("t2_idle");
        chk("t2_idle_busy", 32'(busy_a), 32'd0);
        for (int i = 0; i < 4; i++) step("t2_idle");

        // All channels requesting continuously.
        req = 4'b1111;
        for (int i = 0; i < 80; i++) begin
            din = $urandom;
            step("t3_contend");
        end
        req = '0;
        for (int i = 0; i < 6; i++) step("t3_idle");

        // Async reset while channel 3 drives 0xA5.
        req = 4'b1000;
        din = 32'hA5_00_00_00;
        step("t5_grant");
        step("t5_drive");
        chk("t5_bus_before", 32'(bus_a), 32'hA5);
        chk("t5_gnt_before", 32'(gnt_b), 32'h8);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t5_async");
        chk("t5_async_bus", 32'(bus_a), 32'd0);
        chk("t5_async_gnt", 32'(gnt_a), 32'd0);
        #1;
        rst_n = 1'b1;
        req = 4'b1001;
        din = 32'h5A_00_00_3C;
        step("t5_after");
        chk("t5_after_gnt", 32'(gnt_a), 32'h1);
        req = '0;
        for (int i = 0; i < 6; i++) step("t5_idle");

        // Channel 1 drops while channel 3 waits; instance B has TURN=3.
        req = 4'b0010;
        din = 32'h77_66_55_44;
        step("t4_grant");
        step("t4_hold");
        req = 4'b1010;
        step("t4_hold");
        step("t4_hold");
        req = 4'b1000;
        zc = 0;
        for (int i = 0; i < 10; i++) begin
            step("t4_gap");
            if (gnt_b == '0) zc++;
            else break;
        end
        chk("t4_z_cycles", 32'(zc), 32'd3);
        chk("t4_new_gnt", 32'(gnt_b), 32'h8);

        // A one-cycle request pulse during turnaround, not at the arbitration edge.
        req = '0;
        step("t6_drop");
        req = 4'b0001;
        step("t6_pulse");
        req = '0;
        step("t6_turn");
        step("t6_arb");
        chk("t6_gnt_b", 32'(gnt_b), 32'd0);
        chk("t6_busy_b", 32'(busy_b), 32'd0);
        chk("t6_bus_b", 32'(bus_b), 32'd0);
        for (int i = 0; i < 4; i++) step("t6_idle");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            din = $urandom;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
